// File: rtl/aes_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared constants and state type for the AES frame loader
// Revision: 1.0
// ============================================================================
package aes_pkg;

    localparam int          BLOCK_BYTES = 16;
    localparam logic [3:0]  LAST_BYTE   = 4'(BLOCK_BYTES - 1);

    localparam logic [7:0]  HDR_KEY_DEF = 8'h4B;
    localparam logic [7:0]  HDR_CT_DEF  = 8'h43;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_KEY = 3'd1,
        ST_LOAD_CT  = 3'd2,
        ST_DISCARD  = 3'd3,
        ST_HOLD     = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_frame_loader_if.sv
`default_nettype none
// ============================================================================
// aes_frame_loader_if : byte-stream input and block output handshakes
// Revision: 1.0
// ============================================================================
interface aes_frame_loader_if;

    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, key, ciphertext, out_valid, err
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, key, ciphertext, out_valid, err
    );

endinterface
`default_nettype wire

// File: rtl/aes_frame_loader_byte_shreg.sv
`default_nettype none
// ============================================================================
// aes_byte_shreg : left-shifting byte register, newest byte lands at [7:0]
// Revision: 1.0
// ============================================================================
module aes_byte_shreg #(
    parameter int WIDTH = 128
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             shift_i,
    input  wire logic [7:0]       byte_i,
    output logic      [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            data_q <= '0;
        end else if (shift_i) begin
            data_q <= {data_q[WIDTH-9:0], byte_i};
        end
    end

    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/aes_frame_loader.sv
`default_nettype none
// ============================================================================
// aes_frame_loader : frames header+payload bytes into key/ciphertext blocks
// Revision: 1.0
// ============================================================================
module aes_frame_loader
    import aes_pkg::*;
#(
    parameter logic [7:0] HDR_KEY = HDR_KEY_DEF,
    parameter logic [7:0] HDR_CT  = HDR_CT_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    aes_frame_loader_if.slave  bus
);

    loader_state_t state_q;
    logic [3:0]    cnt_q;
    logic          key_loaded_q;
    logic          out_valid_q;
    logic          err_q;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_last;
    logic          w_key_shift;
    logic          w_ct_shift;
    logic [127:0]  w_key;
    logic [127:0]  w_ct;

    // Ready is a pure state decode so upstream never sees a combinational loop.
    assign w_in_ready  = (state_q != ST_HOLD);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_last      = (cnt_q == LAST_BYTE);
    assign w_key_shift = w_accept && (state_q == ST_LOAD_KEY);
    assign w_ct_shift  = w_accept && (state_q == ST_LOAD_CT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        cnt_q <= 4'd0;
                        if (bus.in_data == HDR_KEY) begin
                            state_q <= ST_LOAD_KEY;
                        end else if (bus.in_data == HDR_CT) begin
                            state_q <= key_loaded_q ? ST_LOAD_CT : ST_DISCARD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD_KEY: begin
                    if (w_accept) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (w_last) begin
                            key_loaded_q <= 1'b1;
                            state_q      <= ST_LOAD_CT;
                        end
                    end
                end
                ST_LOAD_CT: begin
                    if (w_accept) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (w_last) begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_accept) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (w_last) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= 4'd0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    cnt_q       <= 4'd0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // The key register is only rewritten while out_valid is low, so no staging copy is kept.
    aes_byte_shreg #(.WIDTH(128)) u_key_reg (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .shift_i (w_key_shift),
        .byte_i  (bus.in_data),
        .data_o  (w_key)
    );

    aes_byte_shreg #(.WIDTH(128)) u_ct_reg (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .shift_i (w_ct_shift),
        .byte_i  (bus.in_data),
        .data_o  (w_ct)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.key        = w_key;
    assign bus.ciphertext = w_ct;
    assign bus.out_valid  = out_valid_q;
    assign bus.err        = err_q;

endmodule
`default_nettype wire
